// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared definitions for the pipeline controller: the 2-bit
//               controller state encoding, the drain length, default widths
//               and the active-cycle helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 5;
  localparam int CNT_WIDTH_DEFAULT  = 32;

  // Cycles spent draining the back end of the pipeline after HALT.
  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP_WAIT = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_HALTED    = 2'd3
  } state_t;

  // A cycle executes when free-running, or when single-stepping and the
  // step pulse is present.
  function automatic logic is_active(input state_t state, input logic step);
    return (state == ST_RUN) || ((state == ST_STEP_WAIT) && step);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Bundle between the datapath and the pipeline controller.
//               Datapath -> controller: hazard operands, branch, halt and
//               debug step controls. Controller -> datapath: PC / IF-ID load
//               enables, flushes, back-end enable, halted flag, cycle count.
//               master = datapath side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
);

  logic [ADDR_WIDTH-1:0] i_id_rs;
  logic [ADDR_WIDTH-1:0] i_id_rt;
  logic                  i_id_uses_rt;
  logic [ADDR_WIDTH-1:0] i_ex_rt;
  logic                  i_ex_memread;
  logic                  i_branch_taken;
  logic                  i_halt;
  logic                  i_step_mode;
  logic                  i_step;

  logic                  o_pc_write;
  logic                  o_if_id_write;
  logic                  o_if_id_flush;
  logic                  o_id_ex_flush;
  logic                  o_pipe_enable;
  logic                  o_halted;
  logic [CNT_WIDTH-1:0]  o_cycle_count;

  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_rt, i_ex_memread,
    output i_branch_taken, i_halt, i_step_mode, i_step,
    input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
    input  o_pipe_enable, o_halted, o_cycle_count
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_rt, i_ex_memread,
    input  i_branch_taken, i_halt, i_step_mode, i_step,
    output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
    output o_pipe_enable, o_halted, o_cycle_count
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use detector. Flags when the load in EX
//               writes a register that the instruction in ID reads.
//               Register 0 is hard-wired, so it never creates a hazard.
// Ports       : i_id_rs, i_id_rt, i_id_uses_rt - ID source operands
//               i_ex_rt, i_ex_memread          - EX load destination
//               o_load_use                      - stall request
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  wire logic [ADDR_WIDTH-1:0] i_id_rs,
  input  wire logic [ADDR_WIDTH-1:0] i_id_rt,
  input  wire logic                  i_id_uses_rt,
  input  wire logic [ADDR_WIDTH-1:0] i_ex_rt,
  input  wire logic                  i_ex_memread,
  output logic                       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_rt == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
  assign o_load_use = i_ex_memread && (i_ex_rt != '0) && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline controller. Resolves load-use stalls, branch
//               flushes and HALT draining, supports debug single-step, and
//               counts executed cycles.
// Ports       : i_clock - rising-edge clock
//               i_reset - asynchronous active-high reset
//               ctrl    - pipeline_ctrl_if.slave (hazard inputs, pipeline
//                         enables/flushes, halted flag, cycle count)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  wire logic       i_clock,
  input  wire logic       i_reset,
  pipeline_ctrl_if.slave  ctrl
);

  state_t                 r_state;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt;
  logic [CNT_WIDTH-1:0]   r_cycle_count;
  logic                   r_halted;

  logic w_load_use;
  logic w_active;
  logic w_halt_accept;
  logic w_count_en;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_pipe_enable;

  hazard_detect #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hazard_detect (
    .i_id_rs      (ctrl.i_id_rs),
    .i_id_rt      (ctrl.i_id_rt),
    .i_id_uses_rt (ctrl.i_id_uses_rt),
    .i_ex_rt      (ctrl.i_ex_rt),
    .i_ex_memread (ctrl.i_ex_memread),
    .o_load_use   (w_load_use)
  );

  assign w_active = is_active(r_state, ctrl.i_step);

  // Branch wins over everything; a load-use stall defers HALT so the halt
  // is taken on the retried cycle once the hazard has cleared.
  assign w_halt_accept = w_active && ctrl.i_halt && !ctrl.i_branch_taken && !w_load_use;

  assign w_count_en = w_active || (r_state == ST_DRAIN);

  // The enables and flushes must respond to the hazard inputs within the
  // same cycle, so they are decoded combinationally from the state. Reset
  // is folded in so the pipeline sees the reset values immediately.
  always_comb begin
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_pipe_enable = 1'b0;
    if (i_reset) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else begin
      unique case (r_state)
        ST_RUN, ST_STEP_WAIT: begin
          // Idle STEP_WAIT leaves everything at zero: pipeline frozen.
          if (w_active) begin
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_pipe_enable = 1'b1;
            if (ctrl.i_branch_taken) begin
              w_if_id_flush = 1'b1;
              w_id_ex_flush = 1'b1;
            end else if (w_load_use || w_halt_accept) begin
              // Hold PC and IF/ID, inject a bubble into ID/EX.
              w_pc_write    = 1'b0;
              w_if_id_write = 1'b0;
              w_id_ex_flush = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Front end frozen on bubbles while older instructions retire.
          w_pipe_enable = 1'b1;
          w_id_ex_flush = 1'b1;
        end
        ST_HALTED: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= '0;
      r_cycle_count <= '0;
      r_halted      <= 1'b0;
    end else begin
      if (w_count_en) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
      unique case (r_state)
        ST_RUN: begin
          if (w_halt_accept) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end else if (ctrl.i_step_mode) begin
            r_state <= ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          if (w_halt_accept) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end else if (!ctrl.i_step_mode) begin
            r_state <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
          if (r_drain_cnt == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign ctrl.o_pc_write    = w_pc_write;
  assign ctrl.o_if_id_write = w_if_id_write;
  assign ctrl.o_if_id_flush = w_if_id_flush;
  assign ctrl.o_id_ex_flush = w_id_ex_flush;
  assign ctrl.o_pipe_enable = w_pipe_enable;
  assign ctrl.o_halted      = r_halted;
  assign ctrl.o_cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. The driver applies
//               one directed vector per cycle and queues the hand-computed
//               outputs; a negedge monitor pops and compares them.
//               Flag order: {pc_write, if_id_write, if_id_flush,
//               id_ex_flush, pipe_enable, halted}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  localparam logic [5:0] F_DEF   = 6'b110010;
  localparam logic [5:0] F_STALL = 6'b000110;
  localparam logic [5:0] F_BR    = 6'b111110;
  localparam logic [5:0] F_RST   = 6'b001100;
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_HALT  = 6'b000001;

  typedef struct {
    string         name;
    logic [5:0]    flags;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  logic [CW-1:0] exp_cnt;
  exp_t exp_q[$];
  exp_t mon_e;

  pipeline_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  pipeline_ctrl #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .ctrl    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] dut_flags();
    return {bus.o_pc_write, bus.o_if_id_write, bus.o_if_id_flush,
            bus.o_id_ex_flush, bus.o_pipe_enable, bus.o_halted};
  endfunction

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // One cycle: drive inputs after the edge, queue expected outputs for this
  // cycle, then advance the expected count if this cycle is counted.
  task automatic cyc(input string name, input logic r,
                     input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic urt,
                     input logic [AW-1:0] ert, input logic mr,
                     input logic br, input logic hl, input logic sm, input logic st,
                     input logic [5:0] ef, input logic inc);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.i_id_rs        = rs;
    bus.i_id_rt        = rt;
    bus.i_id_uses_rt   = urt;
    bus.i_ex_rt        = ert;
    bus.i_ex_memread   = mr;
    bus.i_branch_taken = br;
    bus.i_halt         = hl;
    bus.i_step_mode    = sm;
    bus.i_step         = st;
    e.name  = name;
    e.flags = ef;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
    if (inc) exp_cnt = exp_cnt + 1;
  endtask

  task automatic run_def(input string name);
    cyc(name, 0, 1, 2, 1, 3, 0, 0, 0, 0, 0, F_DEF, 1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, "_flags"}, {26'd0, dut_flags()}, {26'd0, mon_e.flags});
      check({mon_e.name, "_count"}, bus.o_cycle_count, mon_e.cnt);
    end
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    exp_cnt  = '0;
    rst      = 1'b1;
    bus.i_id_rs = '0; bus.i_id_rt = '0; bus.i_id_uses_rt = 1'b0;
    bus.i_ex_rt = '0; bus.i_ex_memread = 1'b0; bus.i_branch_taken = 1'b0;
    bus.i_halt = 1'b0; bus.i_step_mode = 1'b0; bus.i_step = 1'b0;

    // Reset state
    cyc("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_RST, 0);
    cyc("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_RST, 0);
    run_def("run0");
    run_def("run1");

    // Load-use via rs, then defaults return
    cyc("lu_rs",   0, 5, 2, 0, 5, 1, 0, 0, 0, 0, F_STALL, 1);
    cyc("lu_rs_r", 0, 5, 2, 0, 5, 0, 0, 0, 0, 0, F_DEF,   1);
    // Load-use via rt only counts when rt is read
    cyc("lu_rt",   0, 3, 7, 1, 7, 1, 0, 0, 0, 0, F_STALL, 1);
    cyc("lu_rt_n", 0, 3, 7, 0, 7, 1, 0, 0, 0, 0, F_DEF,   1);
    // Register zero never stalls
    cyc("zero",    0, 0, 0, 1, 0, 1, 0, 0, 0, 0, F_DEF,   1);
    // Branch beats load-use
    cyc("br_lu",   0, 5, 2, 0, 5, 1, 1, 0, 0, 0, F_BR,    1);
    // Branch ignores halt
    cyc("br_halt", 0, 1, 2, 0, 3, 0, 1, 1, 0, 0, F_BR,    1);
    run_def("after_br");

    // Single step: entering cycle still executes, then frozen
    cyc("step_ent", 0, 1, 2, 0, 3, 0, 0, 0, 1, 0, F_DEF, 1);
    for (int i = 0; i < 5; i++)
      cyc("step_idle", 0, 1, 2, 0, 3, 0, 0, 0, 1, 0, F_IDLE, 0);
    cyc("step_pulse", 0, 1, 2, 0, 3, 0, 0, 0, 1, 1, F_DEF, 1);
    cyc("step_idle2", 0, 1, 2, 0, 3, 0, 0, 0, 1, 0, F_IDLE, 0);
    // Leaving step mode: this idle cycle frozen, RUN next edge
    cyc("step_exit", 0, 1, 2, 0, 3, 0, 0, 0, 0, 0, F_IDLE, 0);
    run_def("run_back");

    // Load-use defers halt to the retried cycle
    cyc("lu_halt", 0, 5, 2, 0, 5, 1, 0, 1, 0, 0, F_STALL, 1);
    cyc("halt_acc", 0, 1, 2, 0, 3, 0, 0, 1, 0, 0, F_STALL, 1);
    for (int i = 0; i < 3; i++)
      cyc("drain", 0, 1, 2, 0, 3, 0, 0, 0, 1, 1, F_STALL, 1);
    for (int i = 0; i < 10; i++)
      cyc("halted", 0, 5, 2, 0, 5, 1, 1, 1, 0, 1, F_HALT, 0);

    // Reset out of HALTED
    exp_cnt = '0;
    cyc("rst_halted", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_RST, 0);
    run_def("run_r1");
    run_def("run_r2");

    // Halt, then reset in the middle of DRAIN
    cyc("halt2", 0, 1, 2, 0, 3, 0, 0, 1, 0, 0, F_STALL, 1);
    cyc("drain2", 0, 1, 2, 0, 3, 0, 0, 0, 0, 0, F_STALL, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_flags", {26'd0, dut_flags()}, {26'd0, F_RST});
    check("async_rst_count", bus.o_cycle_count, '0);
    exp_cnt = '0;
    cyc("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_RST, 0);
    run_def("resume0");
    run_def("resume1");
    cyc("resume_lu", 0, 9, 2, 0, 9, 1, 0, 0, 0, 0, F_STALL, 1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_queue got=%0d pending expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
